// File: rtl/chimera_pkg.sv
// Shared types and constants for the Chimera top-level config-register window.
// Holds the APB request/response structs used on the reg-to-APB path, the
// register map offsets/field widths of the cluster power controller, the
// per-cluster power FSM state enum and two small helpers used by that FSM.
package chimera_pkg;

  localparam int ExtClusters = 5;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  localparam logic [11:0] PwrReqOff  = 12'h000;
  localparam logic [11:0] PwrStatOff = 12'h004;
  localparam logic [11:0] BusyOff    = 12'h008;
  localparam logic [11:0] SettleOff  = 12'h00C;
  localparam logic [11:0] IrqStatOff = 12'h010;

  localparam int SettleW = 16;

  typedef enum logic [2:0] {
    CLU_OFF    = 3'd0,
    CLU_UP_CLK = 3'd1,
    CLU_UP_RST = 3'd2,
    CLU_ON     = 3'd3,
    CLU_DN_ISO = 3'd4,
    CLU_DN_RST = 3'd5
  } clu_pwr_state_e;

  // Counter reload value: a timed state lasts max(settle,1) cycles.
  function automatic logic [SettleW-1:0] settle_load(input logic [SettleW-1:0] settle);
    return (settle == '0) ? '0 : settle - 1'b1;
  endfunction

  // Output encoding per state, packed as {clk_en, rst, iso}.
  function automatic logic [2:0] state_outputs(input clu_pwr_state_e s);
    case (s)
      CLU_OFF:    return 3'b011;
      CLU_UP_CLK: return 3'b111;
      CLU_UP_RST: return 3'b101;
      CLU_ON:     return 3'b100;
      CLU_DN_ISO: return 3'b101;
      CLU_DN_RST: return 3'b111;
      default:    return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// Power sequencer for a single cluster: clock gate, synchronous cluster reset
// and AXI isolation, with a 16-bit settle down-counter per timed state.
// Ports: clk_i, rst_i (sync, active-high); req_i target state (1 = on);
// settle_i current SETTLE register; clk_en_o/rst_o/iso_o registered cluster
// controls; on_o / busy_o status; done_o pulses in the cycle a sequence
// finishes (the next edge enters ON or OFF).
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  CLU_OFF    | powered down: clock gated, reset held, isolated
//  CLU_UP_CLK | clock running, reset still held
//  CLU_UP_RST | reset released, still isolated
//  CLU_ON     | fully on, isolation dropped
//  CLU_DN_ISO | isolation raised, clock and reset untouched
//  CLU_DN_RST | reset asserted, clock still running
module chimera_clu_pwr_fsm
  import chimera_pkg::*;
#(
  parameter bit DefaultOn = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic [SettleW-1:0] settle_i,
  output logic               clk_en_o,
  output logic               rst_o,
  output logic               iso_o,
  output logic               on_o,
  output logic               busy_o,
  output logic               done_o
);

  clu_pwr_state_e     state_q, state_d;
  logic [SettleW-1:0] cnt_q, cnt_d;
  logic [2:0]         outs_q;
  logic               expired;

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      CLU_OFF: begin
        if (req_i) begin
          state_d = CLU_UP_CLK;
          cnt_d   = settle_load(settle_i);
        end
      end
      CLU_UP_CLK: begin
        if (expired) begin
          state_d = CLU_UP_RST;
          cnt_d   = settle_load(settle_i);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLU_UP_RST: begin
        if (expired) begin
          state_d = CLU_ON;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLU_ON: begin
        if (!req_i) begin
          state_d = CLU_DN_ISO;
          cnt_d   = settle_load(settle_i);
        end
      end
      CLU_DN_ISO: begin
        if (expired) begin
          state_d = CLU_DN_RST;
          cnt_d   = settle_load(settle_i);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLU_DN_RST: begin
        if (expired) begin
          state_d = CLU_OFF;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = CLU_OFF;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DefaultOn ? CLU_ON : CLU_OFF;
      cnt_q   <= '0;
      outs_q  <= DefaultOn ? 3'b100 : 3'b011;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= state_outputs(state_d);
    end
  end

  assign {clk_en_o, rst_o, iso_o} = outs_q;
  assign on_o   = (state_q == CLU_ON);
  assign busy_o = (state_q != CLU_ON) && (state_q != CLU_OFF);

endmodule

// File: rtl/chimera_cluster_pwr_ctrl.sv
// APB completer for the top-level config-register window. Holds PWR_REQ,
// SETTLE (and IRQ_STAT when built with CHIMERA_CLU_PWR_IRQ_EN) and one power
// FSM per cluster.
// Ports: clk_i, rst_i (sync, active-high); apb_req_i / apb_rsp_o APB
// completer (zero wait-state); clu_clk_en_o, clu_rst_o, clu_iso_o per-cluster
// controls; irq_o sequence-done interrupt (tied 0 without the macro).
// Map (paddr[11:0]): 0x00 PWR_REQ RW, 0x04 PWR_STAT RO, 0x08 BUSY RO,
// 0x0C SETTLE RW, 0x10 IRQ_STAT W1C (macro builds only).
module chimera_cluster_pwr_ctrl
  import chimera_pkg::*;
#(
  parameter int                     NumClusters   = ExtClusters,
  parameter logic [SettleW-1:0]     DefaultSettle = 16'd16,
  parameter logic [NumClusters-1:0] DefaultOn     = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  apb_req_t               apb_req_i,
  output apb_resp_t              apb_rsp_o,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_o,
  output logic [NumClusters-1:0] clu_iso_o,
  output logic                   irq_o
);

  logic [NumClusters-1:0] pwr_req_q, pwr_req_d;
  logic [SettleW-1:0]     settle_q, settle_d;
  logic [NumClusters-1:0] on, busy, seq_done;
  logic [NumClusters-1:0] irq_stat_q;
  logic [11:0]            addr;
  logic [31:0]            rdata;
  logic                   err, access, wr_en;

  assign addr   = apb_req_i.paddr[11:0];
  assign access = apb_req_i.psel && apb_req_i.penable;
  assign wr_en  = access && apb_req_i.pwrite && !err;

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (addr)
      PwrReqOff:  rdata = 32'(pwr_req_q);
      PwrStatOff: begin rdata = 32'(on);   err = apb_req_i.pwrite; end
      BusyOff:    begin rdata = 32'(busy); err = apb_req_i.pwrite; end
      SettleOff:  rdata = 32'(settle_q);
`ifdef CHIMERA_CLU_PWR_IRQ_EN
      IrqStatOff: rdata = 32'(irq_stat_q);
`endif
      default:    err = 1'b1;
    endcase
    if (err) rdata = '0;
  end

  always_comb begin
    apb_rsp_o         = '0;
    apb_rsp_o.pready  = 1'b1;
    apb_rsp_o.prdata  = apb_req_i.psel ? rdata : '0;
    apb_rsp_o.pslverr = access && err;
  end

  // The cluster mask fits in byte 0, so only pstrb[0] qualifies PWR_REQ.
  always_comb begin
    pwr_req_d = pwr_req_q;
    settle_d  = settle_q;
    if (wr_en && addr == PwrReqOff && apb_req_i.pstrb[0])
      pwr_req_d = apb_req_i.pwdata[NumClusters-1:0];
    if (wr_en && addr == SettleOff) begin
      if (apb_req_i.pstrb[0]) settle_d[7:0]  = apb_req_i.pwdata[7:0];
      if (apb_req_i.pstrb[1]) settle_d[15:8] = apb_req_i.pwdata[15:8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwr_req_q <= DefaultOn;
      settle_q  <= DefaultSettle;
    end else begin
      pwr_req_q <= pwr_req_d;
      settle_q  <= settle_d;
    end
  end

  for (genvar g = 0; g < NumClusters; g++) begin : g_clu
    chimera_clu_pwr_fsm #(.DefaultOn(DefaultOn[g])) u_fsm (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (pwr_req_q[g]),
      .settle_i (settle_q),
      .clk_en_o (clu_clk_en_o[g]),
      .rst_o    (clu_rst_o[g]),
      .iso_o    (clu_iso_o[g]),
      .on_o     (on[g]),
      .busy_o   (busy[g]),
      .done_o   (seq_done[g])
    );
  end

`ifdef CHIMERA_CLU_PWR_IRQ_EN
  logic [NumClusters-1:0] irq_stat_d;
  logic                   irq_q;

  // A completion in the same cycle as a W1C keeps the bit set.
  always_comb begin
    irq_stat_d = irq_stat_q;
    if (wr_en && addr == IrqStatOff && apb_req_i.pstrb[0])
      irq_stat_d = irq_stat_q & ~apb_req_i.pwdata[NumClusters-1:0];
    irq_stat_d = irq_stat_d | seq_done;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_q      <= |irq_stat_d;
    end
  end

  assign irq_o = irq_q;

  logic unused_bits;
  assign unused_bits = ^{apb_req_i.paddr[31:12], apb_req_i.pprot,
                         apb_req_i.pwdata[31:16], apb_req_i.pstrb[3:2]};
`else
  assign irq_stat_q = '0;
  assign irq_o      = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{apb_req_i.paddr[31:12], apb_req_i.pprot,
                         apb_req_i.pwdata[31:16], apb_req_i.pstrb[3:2],
                         seq_done, irq_stat_q};
`endif

endmodule

// File: doc/chimera_cluster_pwr_ctrl.md
Name: chimera_cluster_pwr_ctrl

Overview:
- APB completer for the top-level config-register window (TopLevelCfgRegs, 0x3000_1000–0x3000_1FFF).
- It is the responder end of the reg-to-APB path that uses the package's apb_req_t/apb_resp_t.
- Per cluster, it sequences the clock gate, synchronous cluster reset and isolation for power-up and power-down, with a programmable settle time.
- One instance serves all ExtClusters clusters.

Parameters:
- NumClusters, ExtClusters (5), number of controlled clusters.
- DefaultSettle, 16, reset value of SETTLE.
- DefaultOn, '0, per-cluster power state at reset (NumClusters bits).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- apb_req_i  in  apb_req_t  paddr[31:0], pprot, psel, penable, pwrite, pwdata[31:0], pstrb[3:0]
- apb_rsp_o  out  apb_resp_t  pready, prdata[31:0], pslverr
- clu_clk_en_o  out  NumClusters  cluster clock-gate enable
- clu_rst_o  out  NumClusters  cluster reset, active-high
- clu_iso_o  out  NumClusters  AXI isolation request, 1 = isolated
- irq_o  out  1  sequence-done interrupt (see Optional Feature)

Behaviour:
- Decode uses paddr[11:0]; word aligned.
  - 0x00 PWR_REQ RW [NumClusters-1:0]: target state, 1 = on.
  - 0x04 PWR_STAT RO: 1 where FSM is ON.
  - 0x08 BUSY RO: 1 where FSM is not OFF/ON.
  - 0x0C SETTLE RW [15:0].
  - 0x10 IRQ_STAT W1C (feature only).
  - Unused bits read 0.
- APB timing: zero wait-state, pready=1 always. An access completes when psel&penable are high. Writes take effect at that edge.
- pstrb masks write bytes. pstrb=0 writes nothing and gives no error.
- pslverr=1 for unmapped offsets and for writes to RO registers; there is no state change. prdata is 0 on error.
- prdata is combinational from the registers during the access phase and is 0 when not selected.
- Reset:
  - PWR_REQ=DefaultOn, SETTLE=DefaultSettle.
  - Each FSM starts in ON if its DefaultOn bit is set, else OFF.
  - Outputs are consistent with that state: ON gives clk_en=1, rst=0, iso=0; OFF gives clk_en=0, rst=1, iso=1.
  - irq_o=0.
  - Reset mid-sequence aborts immediately to these values.
- Per-cluster FSM, with outputs listed as clk_en/rst/iso:
  - OFF 0/1/1
  - UP_CLK 1/1/1
  - UP_RST 1/0/1
  - ON 1/0/0
  - DN_ISO 1/0/1
  - DN_RST 1/1/1
- Transitions:
  - OFF→UP_CLK when PWR_REQ=1.
  - UP_CLK→UP_RST→ON, each after the settle count expires.
  - ON→DN_ISO when PWR_REQ=0.
  - DN_ISO→DN_RST→OFF, each after the settle count expires.
- Settle counter, one per cluster, 16 bits:
  - Loaded with max(SETTLE,1)-1 on state entry.
  - Decrements each cycle; advances at 0.
  - Each timed state therefore lasts max(SETTLE,1) cycles.
  - SETTLE=0 behaves as 1.
  - The SETTLE value is captured at state entry; a mid-state write takes effect at the next state.
- Latency: with a request written at edge N, outputs change at edge N+1. ON is reached 2*max(SETTLE,1) cycles later.
- PWR_REQ is sampled only in OFF and ON. A toggle during a sequence lets that sequence finish first, then the FSM re-evaluates. There is no direct reversal.
- Simultaneous requests on several clusters run their FSMs in parallel and independently.
- Back-to-back APB accesses are supported every 2 cycles (setup + access).

Optional Feature:
- Macro: CHIMERA_CLU_PWR_IRQ_EN.
- With the macro:
  - IRQ_STAT[i] sets when cluster i enters ON or OFF from a sequence.
  - Writing 1 clears the bit; a same-cycle set wins over the clear.
  - irq_o = |IRQ_STAT, registered.
- Without the macro:
  - Offset 0x10 gives pslverr.
  - irq_o is tied 0; the port stays present.

Decomposition:
- chimera_pkg holds:
  - register offset constants and register field widths;
  - a clu_pwr_state_e enum;
  - the existing apb_req_t/apb_resp_t.
- Sub-module chimera_clu_pwr_fsm: one FSM plus its settle counter. It is instantiated NumClusters times; the top holds APB decode and registers.

Test Plan:
- Reset with DefaultOn=0 → all clu_clk_en_o=0, clu_rst_o=1, clu_iso_o=1; read 0x04 = 0; read 0x0C = 16.
- Write SETTLE=4, then PWR_REQ=0x01 → cluster 0 has clk_en=1 one cycle later, rst=0 at +4, iso=0 at +8; PWR_STAT=0x01; BUSY=0 afterwards.
- Cluster 0 ON, write PWR_REQ=0 then 1 during DN_ISO → full power-down completes to OFF, then power-up restarts automatically.
- Read 0x20 → pslverr=1, prdata=0; write 0x04 → pslverr=1 and PWR_STAT unchanged; write 0x00 with pstrb=0 → no change.
- SETTLE=0 with PWR_REQ=0x1F → all five clusters reach ON 2 cycles after the edge following the write; rst_i asserted mid-sequence → immediate return to reset values.
- With CHIMERA_CLU_PWR_IRQ_EN: sequence completes → IRQ_STAT bit set and irq_o=1; writing 1 to that bit → irq_o=0 next cycle.
